// File: rtl/pc_sequencer_if.sv
// Fetch port between the PC sequencer (master) and the instruction store (slave).
// Handshake: the master holds fetch_req high with PC stable; the word on Instr_in is accepted in the cycle the slave raises fetch_ack.
interface pc_sequencer_if #(
  parameter int n = 8
);
  logic [n-1:0] PC;
  logic         fetch_req;
  logic         fetch_ack;
  logic [n-1:0] Instr_in;

  modport master (
    output PC,
    output fetch_req,
    input  fetch_ack,
    input  Instr_in
  );

  modport slave (
    input  PC,
    input  fetch_req,
    output fetch_ack,
    output Instr_in
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute sequencer for the 8-bit single-stage RISC core.
// One EXEC cycle per fetched instruction; next PC chosen from ImmG and the ALU branch flag.
module pc_sequencer #(
  parameter int         n        = 8,
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [2:0] OP_BEQ   = 3'b100,
  parameter logic [2:0] OP_BLT   = 3'b101,
  parameter logic [2:0] OP_J     = 3'b110
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [n-1:0]         ImmG,
  input  logic                 branch_cond,
  pc_sequencer_if.master       bus,
  output logic [n-1:0]         Instruction,
  output logic                 exec_en,
  output logic                 running,
  output logic                 halted,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] PC0 = n'(RESET_PC);

  state_t       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] instr_q, instr_d;
  logic [2:0]   opcode;
  logic [n-1:0] pc_next;
  logic         self_jump;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign opcode    = instr_q[n-1:n-3];
  assign self_jump = (opcode == OP_J) && (ImmG == '0);

  always_comb begin
    pc_next = pc_q + ONE;
    if (opcode == OP_J) begin
      pc_next = pc_q + ImmG;
    end else if ((opcode == OP_BEQ || opcode == OP_BLT) && branch_cond) begin
      pc_next = pc_q + ImmG;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = PC0;
        end
      end
      S_FETCH: begin
        if (bus.fetch_ack) begin
          instr_d = bus.Instr_in;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // A J with zero offset would spin forever, so it terminates the program.
        pc_d    = pc_next;
        state_d = (halt_req || self_jump) ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PC        = pc_q;
  assign bus.fetch_req = (state_q == S_FETCH);
  assign Instruction   = instr_q;
  assign exec_en       = (state_q == S_EXEC);
  assign running       = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected next-PC values are queued as each
// instruction is fetched and popped when its EXEC cycle retires.
module tb_pc_sequencer;

  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BLT  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic [7:0] ImmG = 8'h00;
  logic       branch_cond = 1'b0;
  logic [7:0] Instruction;
  logic       exec_en, running, halted;
  logic [1:0] state_o;

  pc_sequencer_if #(.n(8)) bus ();

  pc_sequencer #(.n(8), .RESET_PC(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .ImmG        (ImmG),
    .branch_cond (branch_cond),
    .bus         (bus),
    .Instruction (Instruction),
    .exec_en     (exec_en),
    .running     (running),
    .halted      (halted),
    .state_o     (state_o)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_pc  = 8'h00;
  logic [7:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 8'h00;
    check("start_state", state_o, ST_FETCH);
    check("start_pc", bus.PC, 8'h00);
  endtask

  // Drives one instruction through FETCH (immediate ack) and EXEC.
  task automatic run_instr(input logic [2:0] op, input logic [4:0] imm5,
                           input logic cond, input logic hreq);
    logic [7:0] instr, imm, nxt, got;
    logic       stop;
    instr = {op, imm5};
    imm   = {{3{imm5[4]}}, imm5};
    if (op == OP_J)                       nxt = exp_pc + imm;
    else if (op == OP_BEQ || op == OP_BLT) nxt = cond ? exp_pc + imm : exp_pc + 8'd1;
    else                                  nxt = exp_pc + 8'd1;
    stop = hreq || (op == OP_J && imm == 8'h00);
    exp_q.push_back(nxt);
    check("pre_fetch_req", bus.fetch_req, 1'b1);
    bus.fetch_ack = 1'b1;
    bus.Instr_in  = instr;
    ImmG          = imm;
    branch_cond   = cond;
    halt_req      = hreq;
    tick();
    check("exec_en", exec_en, 1'b1);
    check("exec_no_req", bus.fetch_req, 1'b0);
    check("exec_instr", Instruction, instr);
    check("exec_pc_held", bus.PC, exp_pc);
    bus.Instr_in = ~instr;   // ack during EXEC must be ignored
    tick();
    bus.fetch_ack = 1'b0;
    halt_req      = 1'b0;
    got = exp_q.pop_front();
    check("next_pc", bus.PC, got);
    exp_pc = got;
    check("instr_kept", Instruction, instr);
    check("halted", halted, stop);
    check("post_fetch_req", bus.fetch_req, !stop);
    check("post_exec_en", exec_en, 1'b0);
  endtask

  initial begin
    bus.fetch_ack = 1'b0;
    bus.Instr_in  = 8'h00;
    tick();
    tick();
    check("rst_pc", bus.PC, 8'h00);
    check("rst_instr", Instruction, 8'h00);
    check("rst_outs", {bus.fetch_req, exec_en, running, halted}, 4'b0000);
    check("rst_state", state_o, ST_IDLE);
    reset = 1'b0;

    // ack in IDLE is ignored
    bus.fetch_ack = 1'b1;
    bus.Instr_in  = 8'hAA;
    tick();
    tick();
    bus.fetch_ack = 1'b0;
    check("idle_hold", state_o, ST_IDLE);
    check("idle_instr", Instruction, 8'h00);

    // 1: straight-line ADDI program
    pulse_start();
    for (int i = 0; i < 3; i++) run_instr(OP_ADDI, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
    check("addi_pc3", bus.PC, 8'h03);

    // 2: branches from PC=5
    run_instr(OP_J, 5'h02, 1'b0, 1'b0);          // 3 -> 5
    run_instr(OP_BEQ, 5'h03, 1'b1, 1'b0);        // -> 8
    check("beq_taken", bus.PC, 8'h08);
    run_instr(OP_J, 5'h1D, 1'b0, 1'b0);          // 8 - 3 -> 5
    run_instr(OP_BEQ, 5'h03, 1'b0, 1'b0);        // -> 6
    check("beq_not", bus.PC, 8'h06);
    run_instr(OP_J, 5'h1F, 1'b0, 1'b0);          // -> 5
    run_instr(OP_BLT, 5'h03, 1'b1, 1'b0);        // -> 8
    check("blt_taken", bus.PC, 8'h08);
    run_instr(OP_J, 5'h1D, 1'b0, 1'b0);          // -> 5
    run_instr(OP_BLT, 5'h03, 1'b0, 1'b0);        // -> 6
    check("blt_not", bus.PC, 8'h06);

    // 3: negative J wraps, then self-jump terminates
    run_instr(OP_J, 5'h1C, 1'b0, 1'b0);          // 6 - 4 -> 2
    run_instr(OP_J, 5'h1E, 1'b0, 1'b0);          // 2 - 2 -> 0
    check("j_wrap0", bus.PC, 8'h00);
    run_instr(OP_J, 5'h00, 1'b0, 1'b0);
    check("selfjump_pc", bus.PC, 8'h00);
    check("selfjump_state", state_o, ST_HALT);
    bus.fetch_ack = 1'b1;
    halt_req      = 1'b1;
    tick();
    tick();
    bus.fetch_ack = 1'b0;
    check("halt_hold", {halted, running, bus.fetch_req}, 3'b100);
    check("halt_instr", Instruction, 8'hC0);
    pulse_start();
    halt_req = 1'b0;

    // 4: stalled fetch
    run_instr(OP_ADDI, 5'h01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", bus.fetch_req, 1'b1);
      check("stall_pc", bus.PC, 8'h01);
    end
    // start during FETCH is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_fetch_pc", bus.PC, 8'h01);
    check("start_in_fetch_st", state_o, ST_FETCH);
    run_instr(OP_ADDI, 5'h02, 1'b0, 1'b0);

    // 5: halt_req raised while fetching
    halt_req = 1'b1;
    tick();
    run_instr(OP_ADDI, 5'h03, 1'b0, 1'b1);
    check("halt_pc", bus.PC, 8'h03);
    halt_req = 1'b1;
    pulse_start();
    halt_req = 1'b0;

    // wrap at 8'hFF
    run_instr(OP_J, 5'h1F, 1'b0, 1'b0);          // 0 -> FF
    check("pc_ff", bus.PC, 8'hFF);
    run_instr(OP_ADDI, 5'h04, 1'b0, 1'b0);
    check("ff_wrap", bus.PC, 8'h00);

    // 6: async reset mid-EXEC at PC=7F
    run_instr(OP_J, 5'h0F, 1'b0, 1'b0);
    repeat (8) run_instr(OP_J, 5'h0F, 1'b0, 1'b0);  // 0x0F*9 = 0x87
    run_instr(OP_J, 5'h18, 1'b0, 1'b0);             // 0x87 - 8 = 0x7F
    check("pc_7f", bus.PC, 8'h7F);
    bus.fetch_ack = 1'b1;
    bus.Instr_in  = {OP_ADDI, 5'h01};
    tick();
    bus.fetch_ack = 1'b0;
    check("pre_rst_exec", state_o, ST_EXEC);
    #2 reset = 1'b1;
    #1;
    check("arst_pc", bus.PC, 8'h00);
    check("arst_state", state_o, ST_IDLE);
    check("arst_instr", Instruction, 8'h00);
    check("arst_outs", {bus.fetch_req, exec_en, running, halted}, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", state_o, ST_IDLE);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
